io_handshake_ctrl: RTL and testbench
====================================

# io_handshake_ctrl

User I/O handshake controller: the counterpart that drives the `input_flag`, `output_flag` and `insert` stall controls consumed by the program counter. It decodes IN/OUT requests from the core and raises the matching flag to freeze instruction fetch. It then waits for a debounced operator button press, captures switch data or presents output data, and emits a single-cycle `insert` pulse that releases the PC. It sits between the core's decode stage and the board switches, button and display.

## Interface
- `DATA_W`, 32: core data width; width of `in_data`, `out_data` and `display`.
- `SW_W`, 16: switch bus width; `SW_W` ≤ `DATA_W`.
- `DEBOUNCE_CYCLES`, 5: consecutive stable synchronized samples required to accept a button level change.

- `CLK` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `is_in` in 1: core requests an IN; held until `insert`.
- `is_out` in 1: core requests an OUT; held until `insert`.
- `out_data` in DATA_W: value to display for an OUT.
- `switches` in SW_W: operator data switches; asynchronous and static during press.
- `button` in 1: raw operator button; asynchronous, bouncy, active-high.
- `input_flag` out 1: IN pending; PC stalled.
- `output_flag` out 1: OUT pending; PC stalled.
- `insert` out 1: one-cycle release pulse to PC.
- `in_data` out DATA_W: captured switches, zero-extended.
- `display` out DATA_W: latched output value.
- `in_valid` out 1: one-cycle strobe coincident with `insert` on IN completion.

## Operation
- The button path is a 2-flop synchronizer followed by a stability counter.
  - The debounced level `btn_db` changes only after `DEBOUNCE_CYCLES` consecutive samples differ from the current `btn_db`.
  - A differing sample that does not persist resets the counter.
  - `press` is a one-cycle pulse on the rising edge of `btn_db`.
- State machine (`IDLE`, `WAIT_IN`, `WAIT_OUT`, `RELEASE`):
  - `IDLE`:
    - `is_in` → `WAIT_IN`, set `input_flag`.
    - Else `is_out` → `WAIT_OUT`, set `output_flag`, latch `display` ← `out_data`.
    - `is_in` has priority when both are asserted.
  - `WAIT_IN`: on `press`, capture `in_data` ← zero-extended `switches`, pulse `insert` and `in_valid`, go to `RELEASE`.
  - `WAIT_OUT`: on `press`, pulse `insert`, go to `RELEASE`.
  - `RELEASE`:
    - Flags are already cleared.
    - Stay until `btn_db` = 0, then go to `IDLE`.
    - One physical press therefore completes exactly one operation.
- `press` in `IDLE` or `RELEASE` is ignored.
- `display` holds its value until the next OUT is accepted.
- `in_data` holds its value until the next IN completes.
- Reset, at any time including mid-operation:
  - State → `IDLE`.
  - All flags, `insert`, `in_valid`, `in_data`, `display`, synchronizer and counter → 0.
  - `btn_db` → 0.

## Timing
- Request accepted at edge N, where `is_in` or `is_out` is sampled in `IDLE`: the flag is high from N+1.
- Press latency: raw `button` rising → `press` after 2 sync cycles + `DEBOUNCE_CYCLES` cycles. All outputs are registered.
- Cycle K, where `press` is seen in a WAIT state:
  - `insert` = 1 and `in_valid` = 1 during K+1 only.
  - The flag stays high during K+1, so the PC sees `insert` with its flag still set.
  - The flag is 0 from K+2.
- `in_data` is valid from K+1.
- A new request is not accepted until `btn_db` has fallen. The core keeps the next IN/OUT held, so a back-to-back IN waits for release.
- No `press` means the flag is held indefinitely. There is no timeout.

## Structure
- Shared package `io_pkg`:
  - state enum `io_state_t`
  - default `DEBOUNCE_CYCLES`
  - `SW_W`
- Sub-module `button_debounce`:
  - synchronizer, stability counter, `btn_db`, `press`
  - parameter `DEBOUNCE_CYCLES`
  - ports `CLK`, `reset`
- Counter width is $clog2(`DEBOUNCE_CYCLES`+1).
- FSM and data registers live in the top.

## Test plan
- Reset mid-`WAIT_IN` with `input_flag` = 1 → next edge all outputs 0, state `IDLE`; button held during reset produces no `insert`.
- `is_in`=1, `switches`=16'hBEEF, clean press → `input_flag` at N+1; single `insert` + `in_valid`; `in_data`=32'h0000BEEF; flag 0 two cycles after `press`.
- `is_out`=1, `out_data`=32'h12345678 → `display`=32'h12345678 and `output_flag` at N+1; press → one `insert`; `display` retained afterwards.
- Bounce: 3-cycle glitches on `button` with `DEBOUNCE_CYCLES`=5 → no `press`; then hold 8 cycles → exactly one `insert`.
- `is_in` and `is_out` both asserted → only `input_flag` rises; `display` unchanged.
- Button held across two queued IN requests → second request waits in `RELEASE`; no second `insert` until release and a new press.

Source files
------------

// File: rtl/io_pkg.sv
// Shared types and defaults for the user I/O handshake controller.
// Imported by the debouncer and the top-level FSM.
package io_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 5;
  localparam int DEF_SW_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IN  = 2'd1,
    WAIT_OUT = 2'd2,
    RELEASE  = 2'd3
  } io_state_t;

endpackage

// File: rtl/button_debounce.sv
// Operator button conditioning: 2-flop synchronizer, stability counter,
// debounced level and a one-cycle pulse on its rising edge.
module button_debounce
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic CLK,
  input  logic reset,
  input  logic button,
  output logic btn_db,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_btn_db;
  logic          r_press;
  logic          w_diff;
  logic          w_done;

  assign w_diff = r_sync[1] ^ r_btn_db;
  assign w_done = w_diff && (r_cnt == LAST);

  // Any sample matching the current level restarts the count.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_btn_db <= 1'b0;
      r_press  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], button};
      r_press <= w_done & ~r_btn_db;
      if (w_done) begin
        r_btn_db <= ~r_btn_db;
        r_cnt    <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + ONE;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign btn_db = r_btn_db;
  assign press  = r_press;

endmodule

// File: rtl/io_handshake_ctrl.sv
// IN/OUT handshake FSM: stalls the PC via flags until an operator press,
// then captures switches or keeps the display and pulses insert.
module io_handshake_ctrl
  import io_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SW_W = DEF_SW_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              is_in,
  input  logic              is_out,
  input  logic [DATA_W-1:0] out_data,
  input  logic [SW_W-1:0]   switches,
  input  logic              button,
  output logic              input_flag,
  output logic              output_flag,
  output logic              insert,
  output logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] display,
  output logic              in_valid
);

  io_state_t         r_state;
  io_state_t         w_state_nxt;
  logic              r_in_flag;
  logic              r_out_flag;
  logic              r_insert;
  logic              r_in_valid;
  logic [DATA_W-1:0] r_in_data;
  logic [DATA_W-1:0] r_display;
  logic              w_in_flag_nxt;
  logic              w_out_flag_nxt;
  logic              w_insert_nxt;
  logic              w_in_valid_nxt;
  logic [DATA_W-1:0] w_in_data_nxt;
  logic [DATA_W-1:0] w_display_nxt;
  logic              w_btn_db;
  logic              w_press;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .CLK   (CLK),
    .reset (reset),
    .button(button),
    .btn_db(w_btn_db),
    .press (w_press)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_in_flag  <= 1'b0;
      r_out_flag <= 1'b0;
      r_insert   <= 1'b0;
      r_in_valid <= 1'b0;
      r_in_data  <= '0;
      r_display  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_flag  <= w_in_flag_nxt;
      r_out_flag <= w_out_flag_nxt;
      r_insert   <= w_insert_nxt;
      r_in_valid <= w_in_valid_nxt;
      r_in_data  <= w_in_data_nxt;
      r_display  <= w_display_nxt;
    end
  end

  // Flags survive the insert cycle and drop on leaving it, so the
  // PC always sees insert together with its own flag.
  always_comb begin
    w_state_nxt    = r_state;
    w_in_flag_nxt  = r_in_flag;
    w_out_flag_nxt = r_out_flag;
    w_insert_nxt   = 1'b0;
    w_in_valid_nxt = 1'b0;
    w_in_data_nxt  = r_in_data;
    w_display_nxt  = r_display;
    unique case (r_state)
      IDLE: begin
        if (is_in) begin
          w_state_nxt   = WAIT_IN;
          w_in_flag_nxt = 1'b1;
        end else if (is_out) begin
          w_state_nxt    = WAIT_OUT;
          w_out_flag_nxt = 1'b1;
          w_display_nxt  = out_data;
        end
      end
      WAIT_IN: begin
        if (w_press) begin
          w_state_nxt    = RELEASE;
          w_insert_nxt   = 1'b1;
          w_in_valid_nxt = 1'b1;
          w_in_data_nxt  = DATA_W'(switches);
        end
      end
      WAIT_OUT: begin
        if (w_press) begin
          w_state_nxt  = RELEASE;
          w_insert_nxt = 1'b1;
        end
      end
      RELEASE: begin
        w_in_flag_nxt  = 1'b0;
        w_out_flag_nxt = 1'b0;
        if (!w_btn_db) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign input_flag  = r_in_flag;
  assign output_flag = r_out_flag;
  assign insert      = r_insert;
  assign in_valid    = r_in_valid;
  assign in_data     = r_in_data;
  assign display     = r_display;

endmodule

// File: tb/tb_io_handshake_ctrl.sv
// Bench for io_handshake_ctrl: vector table, directed corner sequences
// and random traffic against a transaction-level reference model.
module tb_io_handshake_ctrl;
  import io_pkg::*;

  localparam int D = 5;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        is_in = 1'b0;
  logic        is_out = 1'b0;
  logic [31:0] out_data = '0;
  logic [15:0] switches = '0;
  logic        button = 1'b0;
  logic        input_flag;
  logic        output_flag;
  logic        insert;
  logic [31:0] in_data;
  logic [31:0] display;
  logic        in_valid;

  int n_checks = 0;
  int n_fail = 0;

  io_handshake_ctrl #(
    .DATA_W(32),
    .SW_W(16),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .CLK        (CLK),
    .reset      (rst_n),
    .is_in      (is_in),
    .is_out     (is_out),
    .out_data   (out_data),
    .switches   (switches),
    .button     (button),
    .input_flag (input_flag),
    .output_flag(output_flag),
    .insert     (insert),
    .in_data    (in_data),
    .display    (display),
    .in_valid   (in_valid)
  );

  always #5 CLK = ~CLK;

  // Reference model: expected outputs plus abstract button history.
  bit          e_inf, e_outf, e_ins, e_val;
  logic [31:0] e_ind, e_disp;
  bit          m_db, m_press, m_locked;
  bit          sq[$];
  bit          win[$];

  task automatic model_clear();
    e_inf = 0; e_outf = 0; e_ins = 0; e_val = 0;
    e_ind = '0; e_disp = '0;
    m_db = 0; m_press = 0; m_locked = 0;
    sq = '{1'b0, 1'b0};
    win.delete();
  endtask

  task automatic model_edge();
    bit n_ins, n_val, samp, all_diff;
    if (!rst_n) begin
      model_clear();
      return;
    end
    n_ins = 0;
    n_val = 0;
    if (e_ins) begin
      e_inf = 0;
      e_outf = 0;
    end
    if (m_locked) begin
      if (!m_db) m_locked = 0;
    end else if (e_inf || e_outf) begin
      if (m_press) begin
        n_ins = 1;
        n_val = e_inf;
        if (e_inf) e_ind = {16'h0, switches};
        m_locked = 1;
      end
    end else if (is_in) begin
      e_inf = 1;
    end else if (is_out) begin
      e_outf = 1;
      e_disp = out_data;
    end
    e_ins = n_ins;
    e_val = n_val;
    // Button seen two edges late; level flips once D samples disagree.
    samp = sq.pop_front();
    sq.push_back(button);
    win.push_back(samp);
    if (win.size() > D) void'(win.pop_front());
    all_diff = (win.size() == D);
    foreach (win[k]) if (win[k] == m_db) all_diff = 0;
    m_press = 0;
    if (all_diff) begin
      m_db = ~m_db;
      m_press = m_db;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    chk("model_ctl",
        32'({input_flag, output_flag, insert, in_valid}),
        32'({e_inf, e_outf, e_ins, e_val}));
    chk("model_in_data", in_data, e_ind);
    chk("model_display", display, e_disp);
  endtask

  task automatic drive(input bit r, input bit i, input bit o,
                       input bit b, input logic [31:0] od,
                       input logic [15:0] sw);
    rst_n = r; is_in = i; is_out = o; button = b;
    out_data = od; switches = sw;
  endtask

  typedef struct {
    bit          r, i, o, b;
    logic [31:0] od;
    logic [15:0] sw;
    int          n;
    bit          einf, eoutf;
    int          nins;
    logic [31:0] eind, edisp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit i, bit o, bit b,
                              logic [31:0] od, logic [15:0] sw, int n,
                              bit einf, bit eoutf, int nins,
                              logic [31:0] eind, logic [31:0] edisp);
    vec_t v;
    v.r = r; v.i = i; v.o = o; v.b = b; v.od = od; v.sw = sw; v.n = n;
    v.einf = einf; v.eoutf = eoutf; v.nins = nins;
    v.eind = eind; v.edisp = edisp;
    return v;
  endfunction

  initial begin
    int ins_cnt, left;
    model_clear();
    tbl.push_back(mk(0,0,0,0,0,16'h0,2, 0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,16'hBEEF,1, 1,0,0,0,0));
    tbl.push_back(mk(1,1,0,1,0,16'hBEEF,7, 1,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,0,16'hBEEF,2, 0,0,1,32'hBEEF,0));
    tbl.push_back(mk(1,0,0,0,0,16'hBEEF,10, 0,0,0,32'hBEEF,0));
    tbl.push_back(mk(1,0,1,0,32'h12345678,16'hBEEF,1,
                     0,1,0,32'hBEEF,32'h12345678));
    tbl.push_back(mk(1,0,1,1,32'h12345678,16'hBEEF,7,
                     0,1,0,32'hBEEF,32'h12345678));
    tbl.push_back(mk(1,0,0,1,0,16'hBEEF,2, 0,0,1,32'hBEEF,32'h12345678));
    tbl.push_back(mk(1,0,0,0,0,16'hBEEF,10, 0,0,0,32'hBEEF,32'h12345678));
    tbl.push_back(mk(1,1,1,0,32'hCAFEF00D,16'h0001,1,
                     1,0,0,32'hBEEF,32'h12345678));
    tbl.push_back(mk(1,1,1,1,32'hCAFEF00D,16'h0001,7,
                     1,0,0,32'hBEEF,32'h12345678));
    tbl.push_back(mk(1,1,0,1,0,16'h0001,2, 0,0,1,32'h1,32'h12345678));
    tbl.push_back(mk(1,1,0,1,0,16'hA5A5,20, 0,0,0,32'h1,32'h12345678));
    tbl.push_back(mk(1,1,0,0,0,16'hA5A5,8, 0,0,0,32'h1,32'h12345678));
    tbl.push_back(mk(1,1,0,0,0,16'hA5A5,1, 1,0,0,32'h1,32'h12345678));
    tbl.push_back(mk(1,1,0,1,0,16'hA5A5,7, 1,0,0,32'h1,32'h12345678));
    tbl.push_back(mk(1,0,0,1,0,16'hA5A5,2, 0,0,1,32'hA5A5,32'h12345678));
    tbl.push_back(mk(1,0,0,0,0,16'hA5A5,10, 0,0,0,32'hA5A5,32'h12345678));

    foreach (tbl[t]) begin
      drive(tbl[t].r, tbl[t].i, tbl[t].o, tbl[t].b, tbl[t].od, tbl[t].sw);
      ins_cnt = 0;
      repeat (tbl[t].n) begin
        step();
        ins_cnt += int'(insert);
      end
      chk($sformatf("vec%0d_in_flag", t), 32'(input_flag), 32'(tbl[t].einf));
      chk($sformatf("vec%0d_out_flag", t), 32'(output_flag),
          32'(tbl[t].eoutf));
      chk($sformatf("vec%0d_inserts", t), ins_cnt, tbl[t].nins);
      chk($sformatf("vec%0d_in_data", t), in_data, tbl[t].eind);
      chk($sformatf("vec%0d_display", t), display, tbl[t].edisp);
    end

    // Reset in the middle of WAIT_IN with the button already pressed.
    drive(1, 1, 0, 0, 0, 16'h1234);
    step();
    button = 1'b1;
    repeat (4) step();
    chk("rst_pre_flag", 32'(input_flag), 32'd1);
    rst_n = 1'b0;
    is_in = 1'b0;
    #1;
    chk("rst_async_outs",
        32'({input_flag, output_flag, insert, in_valid}), 32'd0);
    chk("rst_async_data", in_data | display, 32'd0);
    ins_cnt = 0;
    repeat (3) begin
      step();
      ins_cnt += int'(insert);
    end
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    rst_n = 1'b1;
    repeat (15) begin
      step();
      ins_cnt += int'(insert);
    end
    chk("rst_held_btn_inserts", ins_cnt, 0);
    button = 1'b0;
    repeat (10) step();

    // Short glitches must never reach press; a solid hold gives one insert.
    is_in = 1'b1;
    switches = 16'h0F0F;
    step();
    ins_cnt = 0;
    repeat (3) begin
      button = 1'b1;
      repeat (3) begin step(); ins_cnt += int'(insert); end
      button = 1'b0;
      repeat (3) begin step(); ins_cnt += int'(insert); end
    end
    chk("bounce_no_insert", ins_cnt, 0);
    chk("bounce_flag_held", 32'(input_flag), 32'd1);
    button = 1'b1;
    repeat (8) begin step(); ins_cnt += int'(insert); end
    is_in = 1'b0;
    repeat (4) begin step(); ins_cnt += int'(insert); end
    chk("bounce_one_insert", ins_cnt, 1);
    chk("bounce_in_data", in_data, 32'h0000_0F0F);
    button = 1'b0;
    repeat (10) step();

    // Random traffic; the core holds each request until insert.
    left = 0;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      if (e_ins) begin
        is_in = 1'b0;
        is_out = 1'b0;
      end else if (!is_in && !is_out && $urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0: is_in = 1'b1;
          1: is_out = 1'b1;
          default: begin is_in = 1'b1; is_out = 1'b1; end
        endcase
        out_data = $urandom;
        switches = 16'($urandom);
      end
      if (left == 0) begin
        button = ~button;
        left = $urandom_range(1, 14);
      end
      left--;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
